// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory word
// address, absorbs the one-cycle read latency and presents a valid/ready stream.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  logic        hold;
  logic        fire;
  logic        run_now;
  logic        redirect_ok;
  logic        redirect_bad;
  logic [29:0] issue_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      fetch_pc_q     <= RESET_PC;
      resp_pc_q      <= RESET_PC;
      resp_valid_q   <= 1'b0;
      fault_q        <= 1'b0;
      fault_pc_q     <= '0;
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      resp_pc_q      <= resp_pc_d;
      resp_valid_q   <= resp_valid_d;
      fault_q        <= fault_d;
      fault_pc_q     <= fault_pc_d;
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  always_comb begin
    out_valid    = resp_valid_q && (state_q != ST_FAULT) && !redirect_valid;
    hold         = out_valid && !out_ready;
    fire         = out_valid && out_ready;
    redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Whether this cycle behaves as RUN: HALT resumes immediately on fetch_en,
    // RUN drops to HALT only when neither fetch_en nor a redirect keeps it going.
    run_now      = (state_q == ST_HALT) ? fetch_en
                 : ((state_q == ST_RUN) && (fetch_en || redirect_valid));

    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    resp_pc_d      = resp_pc_q;
    resp_valid_d   = resp_valid_q;
    fault_d        = fault_q;
    fault_pc_d     = fault_pc_q;
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    issue_word     = fetch_pc_q[31:2];

    if (state_q != ST_FAULT) begin
      state_d = run_now ? ST_RUN : ST_HALT;
      if (redirect_ok) begin
        if (run_now) begin
          issue_word   = redirect_pc[31:2];
          resp_pc_d    = redirect_pc;
          resp_valid_d = 1'b1;
          fetch_pc_d   = redirect_pc + 32'd4;
        end else begin
          fetch_pc_d   = redirect_pc;
          resp_valid_d = 1'b0;
        end
      end else if (redirect_bad) begin
        state_d      = ST_FAULT;
        fault_d      = 1'b1;
        fault_pc_d   = redirect_pc;
        resp_valid_d = 1'b0;
      end else if (hold) begin
        // Re-read the held word so idata stays stable while decode stalls.
        issue_word = resp_pc_q[31:2];
      end else if (run_now) begin
        resp_pc_d    = fetch_pc_q;
        resp_valid_d = 1'b1;
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end else begin
        resp_valid_d = 1'b0;
      end
    end

    if (fire) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (hold) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  assign iaddr        = {2'b00, issue_word};
  assign out_instr    = idata;
  assign out_pc       = resp_pc_q;
  assign fault        = fault_q;
  assign fault_pc     = fault_pc_q;
  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued as stimulus is
// driven and checked against each handshake transfer, plus inline state checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  logic [31:0] imem [0:1023];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .iaddr          (iaddr),
    .idata          (idata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory, only iaddr[9:0] decoded.
  always @(posedge clk) idata <= imem[iaddr[9:0]];

  // One clock cycle: at the falling edge any handshake transfer is popped
  // against the scoreboard; returns just after the next rising edge.
  task automatic tick();
    logic [31:0] epc;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL xfer_unexpected: out_pc=%h out_instr=%h required no transfer", out_pc, out_instr);
      end else begin
        epc = exp_q.pop_front();
        if (out_pc !== epc || out_instr !== imem[epc[11:2]]) begin
          n_err++;
          $display("FAIL xfer: out_pc=%h out_instr=%h required pc=%h instr=%h",
                   out_pc, out_instr, epc, imem[epc[11:2]]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick(); tick();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || iaddr !== 32'h0 || fault !== 1'b0 || fault_pc !== 32'h0 ||
        perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b iaddr=%h fault=%b fpc=%h fetched=%0d stall=%0d required 0s",
               out_valid, iaddr, fault, fault_pc, perf_fetched, perf_stall);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int unsigned i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || iaddr !== 32'h0) begin
      n_err++;
      $display("FAIL stream_first_issue: valid=%b iaddr=%h required 0 0", out_valid, iaddr);
    end
    for (int unsigned i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (exp_q.size() != 0 || perf_fetched !== 32'd4) begin
      n_err++;
      $display("FAIL stream_count: pending=%0d fetched=%0d required 0 4", exp_q.size(), perf_fetched);
    end
  endtask

  task automatic test_stall();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick(); tick();
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== imem[1] || iaddr !== 32'h1) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h iaddr=%h required 1 4 %h 1",
                 out_valid, out_pc, out_instr, iaddr, imem[1]);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (perf_stall !== 32'd3 || iaddr !== 32'h2) begin
      n_err++;
      $display("FAIL stall_release: stall=%0d iaddr=%h required 3 2", perf_stall, iaddr);
    end
    tick(); tick();
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (exp_q.size() != 0 || perf_fetched !== 32'd3) begin
      n_err++;
      $display("FAIL stall_count: pending=%0d fetched=%0d required 0 3", exp_q.size(), perf_fetched);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_pc !== 32'h8 || iaddr !== 32'h10) begin
      n_err++;
      $display("FAIL redirect_squash: valid=%b pc=%h iaddr=%h required 0 8 10", out_valid, out_pc, iaddr);
    end
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (exp_q.size() != 0 || perf_fetched !== 32'd4) begin
      n_err++;
      $display("FAIL redirect_count: pending=%0d fetched=%0d required 0 4", exp_q.size(), perf_fetched);
    end
  endtask

  task automatic test_halt();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick();
    fetch_en = 1'b0;
    tick();
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || perf_fetched !== 32'd1 || perf_stall !== 32'd0) begin
        n_err++;
        $display("FAIL halt_idle: valid=%b fetched=%0d stall=%0d required 0 1 0",
                 out_valid, perf_fetched, perf_stall);
      end
      tick();
    end
    fetch_en = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || iaddr !== 32'h1) begin
      n_err++;
      $display("FAIL halt_resume_issue: valid=%b iaddr=%h required 0 1", out_valid, iaddr);
    end
    tick(); tick(); tick();
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (exp_q.size() != 0 || perf_fetched !== 32'd3 || out_pc !== 32'hC) begin
      n_err++;
      $display("FAIL halt_count: pending=%0d fetched=%0d pc=%h required 0 3 c",
               exp_q.size(), perf_fetched, out_pc);
    end
  endtask

  task automatic test_fault();
    do_reset();
    exp_q.push_back(32'h0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL fault_entry: valid=%b fault=%b required 0 0", out_valid, fault);
    end
    tick();
    redirect_pc = 32'h80;
    #1;
    n_vec++;
    if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fault_set: fault=%b fpc=%h valid=%b required 1 42 0", fault, fault_pc, out_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || fault_pc !== 32'h42 || perf_fetched !== 32'd1 || iaddr !== 32'h2) begin
      n_err++;
      $display("FAIL fault_terminal: valid=%b fpc=%h fetched=%0d iaddr=%h required 0 42 1 2",
               out_valid, fault_pc, perf_fetched, iaddr);
    end
    tick(); tick();
    rst_n = 1'b0;
    tick();
    #1;
    n_vec++;
    if (fault !== 1'b0 || fault_pc !== 32'h0 || perf_fetched !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fault_clear: fault=%b fpc=%h fetched=%0d valid=%b required 0 0 0 0",
               fault, fault_pc, perf_fetched, out_valid);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL fault_pending: pending=%0d required 0", exp_q.size());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset();
    exp_q.push_back(32'h0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    #1;
    n_vec++;
    if (iaddr !== 32'h3FFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_iaddr: iaddr=%h required 3fffffff", iaddr);
    end
    tick();
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (exp_q.size() != 0 || perf_fetched !== 32'd4) begin
      n_err++;
      $display("FAIL wrap_count: pending=%0d fetched=%0d required 0 4", exp_q.size(), perf_fetched);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int got;
    do_reset();
    for (int unsigned i = 0; i < 300; i++) exp_q.push_back(32'(i * 4));
    base = n_pop;
    for (int unsigned c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      fetch_en  = ($urandom_range(0, 4) != 0);
      tick();
    end
    out_ready = 1'b0;
    #1;
    got = n_pop - base;
    n_vec++;
    if (perf_fetched !== 32'(got) || exp_q.size() != 300 - got || got < 100) begin
      n_err++;
      $display("FAIL random_stream: fetched=%0d transfers=%0d pending=%0d required equal, pending=%0d",
               perf_fetched, got, exp_q.size(), 300 - got);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int unsigned i = 0; i < 1024; i++) imem[i] = 32'hA000_0000 ^ (i * 32'h0001_0101);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_fault();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the memory's word address, and absorbs the memory's one-cycle registered read latency. It presents each fetched instruction to decode through a valid/ready handshake. It also handles downstream stalls, branch redirects, a fetch enable, misaligned-target faults and two performance counters.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- fetch_en  input  1  1 = issue new fetches; 0 = stop issuing (drain/hold)
- redirect_valid  input  1  branch/jump redirect this cycle
- redirect_pc  input  32  byte target of redirect
- iaddr  output  32  word index to instruction memory, {2'b00, pc[31:2]}
- idata  input  32  instruction memory read data, valid one cycle after iaddr
- out_valid  output  1  out_instr/out_pc hold a valid instruction
- out_ready  input  1  decode accepts when out_valid && out_ready
- out_instr  output  32  instruction (driven from idata)
- out_pc  output  32  byte address of out_instr
- fault  output  1  sticky misaligned-redirect fault
- fault_pc  output  32  offending redirect_pc
- perf_fetched  output  32  count of accepted instructions
- perf_stall  output  32  count of cycles with out_valid && !out_ready

## Operation
- State registers:
  - fetch_pc: next byte address to issue.
  - resp_pc: address whose data is on idata.
  - resp_valid: idata is meaningful.
  - state: RUN, HALT or FAULT.
- Reset (rst_n=0 at a clk edge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC, resp_valid=0, state=RUN.
  - fault=0, fault_pc=0, perf_fetched=0, perf_stall=0.
  - Outputs: out_valid=0, iaddr={2'b00, RESET_PC[31:2]}.
- out_valid = resp_valid && state!=FAULT && !redirect_valid. A redirect squashes the instruction presented in the same cycle.
- out_instr = idata; out_pc = resp_pc.
- hold = out_valid && !out_ready.
- Per-cycle priority, highest first:
  1. Aligned redirect (redirect_pc[1:0]==0):
     - In RUN: iaddr from redirect_pc; resp_pc<=redirect_pc, resp_valid<=1, fetch_pc<=redirect_pc+4.
     - In HALT: fetch_pc<=redirect_pc, resp_valid<=0.
  2. Misaligned redirect (redirect_pc[1:0]!=0), any state except FAULT:
     - state<=FAULT, fault<=1, fault_pc<=redirect_pc, resp_valid<=0.
  3. hold:
     - iaddr from resp_pc, which re-reads the same word so idata stays stable.
     - resp_pc, resp_valid and fetch_pc are unchanged.
  4. RUN, no hold:
     - iaddr from fetch_pc; resp_pc<=fetch_pc, resp_valid<=1, fetch_pc<=fetch_pc+4.
  5. HALT, no hold:
     - resp_valid<=0; iaddr from fetch_pc, and the read result is ignored.
- State transitions:
  - RUN to HALT when fetch_en=0 and no redirect. That cycle follows case 3 or case 5, not case 4.
  - HALT to RUN when fetch_en=1. New issue starts in the same cycle as the HALT-to-RUN transition.
  - FAULT is terminal until reset. In FAULT, iaddr=fetch_pc, out_valid=0, counters freeze and redirects are ignored.
- Arithmetic:
  - PC increment is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - The memory uses only iaddr[9:0]; aliasing above 4 KiB is not detected.
- Counters:
  - perf_fetched increments on each out_valid && out_ready.
  - perf_stall increments on each hold cycle.
  - Both wrap at 2^32.

## Timing
- iaddr is combinational from redirect_valid, redirect_pc, out_ready and state registers. This is a single mux level, and the critical path runs out_ready to iaddr.
- Latency:
  - From address issue to out_valid: 1 cycle.
  - From reset release: the first rising clk with rst_n=1 issues RESET_PC, and out_valid=1 in the following cycle.
- Throughput is 1 instruction/cycle with out_ready held high.
- A redirect costs zero bubble cycles: the target instruction appears 1 cycle after redirect_valid.
- Stall release:
  - out_instr is unchanged for every hold cycle.
  - On the cycle out_ready rises, the held item transfers and fetch_pc is issued, giving the next instruction 1 cycle later.
- A redirect and out_ready in the same cycle produce no transfer, because out_valid is masked.
- Reset mid-operation discards any in-flight response and any fault.

## Test plan
- Streaming:
  - Stimulus: RESET_PC=0, IMEM[0..3]=A0..A3, out_ready=1, fetch_en=1, release reset.
  - Required: out_pc=0,4,8,12 with out_instr=A0..A3 on consecutive cycles starting 1 cycle after release; perf_fetched=4.
- Stall:
  - Stimulus: drop out_ready for 3 cycles while out_pc=4.
  - Required: out_pc=4 and out_instr=A1 held for 3 cycles, iaddr=1 during the hold, perf_stall=3; then out_pc=8 follows 1 cycle after the held transfer.
- Redirect:
  - Stimulus: redirect_valid=1 with redirect_pc=0x40 while out_pc=8 is presented.
  - Required: out_valid=0 that cycle, no transfer, next cycle out_pc=0x40 with out_instr=IMEM[16], then out_pc=0x44.
- Halt:
  - Stimulus: fetch_en=0 for 4 cycles, then fetch_en=1.
  - Required: out_valid=0 after the current item drains, no counter change; resume at the next sequential pc with no skipped or duplicated address.
- Fault:
  - Stimulus: redirect_pc=0x42.
  - Required: fault=1 and fault_pc=0x42 next cycle; out_valid stays 0 and redirect_pc=0x80 is ignored; rst_n=0 clears fault=0, perf_fetched=0, out_valid=0.
- Wrap:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: out_pc=0xFFFF_FFFC, then 0x0000_0000.
